// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
//
// A bank of CHANNELS independent WIDTH-bit counters. Each channel has its own
// count register, limit register, sticky done flag and a one-cycle tick pulse.
// A channel counts up towards its limit or down towards zero. In wrap mode it
// reloads at the terminal value. In one-shot mode it stops there and sets done.
//
// Parameters
//   CHANNELS    number of independent channels (>= 1)
//   WIDTH       bit width of each count and limit (>= 2)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   en          [CHANNELS]          per-channel advance request
//   set_valid   [CHANNELS]          per-channel load strobe
//   set_value   [CHANNELS*WIDTH]    load value, channel i at [i*WIDTH +: WIDTH]
//   limit_valid [CHANNELS]          per-channel limit write strobe
//   limit_value [CHANNELS*WIDTH]    new limit, packed as set_value
//   mode        [2*CHANNELS]        bit0 one-shot(1)/wrap(0), bit1 down(1)/up(0)
//   count       [CHANNELS*WIDTH]    registered count, packed as set_value
//   last        [CHANNELS]          combinational terminal indication
//   done        [CHANNELS]          registered sticky one-shot-expired flag
//   tick        [CHANNELS]          registered one-cycle terminal-event pulse
// -----------------------------------------------------------------------------
module counter_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       set_valid,
  input  logic [CHANNELS*WIDTH-1:0] set_value,
  input  logic [CHANNELS-1:0]       limit_valid,
  input  logic [CHANNELS*WIDTH-1:0] limit_value,
  input  logic [2*CHANNELS-1:0]     mode,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       last,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             done_q;
    logic             tick_q;
    logic             one_shot;
    logic             down;
    logic             last_c;

    assign one_shot = mode[2*i];
    assign down     = mode[2*i+1];

    // Terminal detection uses the registered limit, so a limit write in the
    // current cycle only affects decisions from the next cycle onwards.
    assign last_c = down ? (count_q == '0) : (count_q == limit_q);

    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every channel
      // samples the pre-edge values of count_q/limit_q/done_q together.
      if (rst) begin
        count_q <= '0;
        limit_q <= '1;
        done_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (limit_valid[i]) begin
          limit_q <= limit_value[i*WIDTH +: WIDTH];
        end

        // NOTE: tick defaults low each cycle and is raised only by a terminal
        // event below, which is what makes it a single-cycle pulse.
        tick_q <= 1'b0;

        if (set_valid[i]) begin
          count_q <= set_value[i*WIDTH +: WIDTH];
          done_q  <= 1'b0;
        end else if (en[i] && !done_q) begin
          if (!last_c) begin
            // A count above the limit in up mode simply runs on through
            // all-ones to zero; that roll-over is not a terminal event.
            count_q <= down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
          end else if (!one_shot) begin
            // Down-mode reload uses limit_q, i.e. the old limit when a limit
            // write lands in the same cycle.
            count_q <= down ? limit_q : '0;
            tick_q  <= 1'b1;
          end else begin
            done_q <= 1'b1;
            tick_q <= 1'b1;
          end
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = count_q;
    assign last[i]                 = last_c;
    assign done[i]                 = done_q;
    assign tick[i]                 = tick_q;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent counter channels, minimum 1.
REQ-002 Parameter WIDTH, default 16: bit width of each channel's count and limit, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 en  input  CHANNELS  per-channel advance request.
REQ-006 set_valid  input  CHANNELS  per-channel load strobe.
REQ-007 set_value  input  CHANNELS*WIDTH  per-channel load value; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 limit_valid  input  CHANNELS  per-channel limit-register write strobe.
REQ-009 limit_value  input  CHANNELS*WIDTH  per-channel new limit, packed as set_value.
REQ-010 mode  input  2*CHANNELS  per channel: bit0 = one-shot (1) or wrap (0); bit1 = down (1) or up (0).
REQ-011 count  output  CHANNELS*WIDTH  per-channel registered count, packed as set_value.
REQ-012 last  output  CHANNELS  per-channel terminal indication, combinational from count, limit and mode.
REQ-013 done  output  CHANNELS  per-channel sticky one-shot-expired flag, registered.
REQ-014 tick  output  CHANNELS  per-channel one-cycle terminal-event pulse, registered.

Function
REQ-015 Each channel SHALL hold a WIDTH-bit count register and a WIDTH-bit limit register; channels share nothing except clk and rst.
REQ-016 last SHALL be (count == limit) in up mode and (count == 0) in down mode, using the current limit register and current mode.
REQ-017 Priority per channel, highest first: rst; set_valid; en. set_valid SHALL load count <= set_value, clear done, and suppress tick, regardless of en.
REQ-018 en with last low SHALL step count by +1 in up mode and -1 in down mode, modulo 2^WIDTH.
REQ-019 en with last high in wrap mode SHALL reload count to 0 in up mode or to limit in down mode, and SHALL assert tick in the next cycle.
REQ-020 en with last high in one-shot mode and done low SHALL hold count, set done, and assert tick in the next cycle.
REQ-021 While done is high, en SHALL be ignored: count holds and tick stays low.
REQ-022 tick SHALL be high for exactly one cycle per terminal event; back-to-back terminal events (e.g. limit 0 in up mode with en held) SHALL yield tick high on consecutive cycles.
REQ-023 limit_valid SHALL write limit_value into the limit register at the clock edge; in that same cycle, last and the wrap/reload decision SHALL use the old limit.
REQ-024 If limit_valid and a down-mode reload occur in the same cycle, the reload value SHALL be the old limit.
REQ-025 If count exceeds limit in up mode (limit lowered, or set_value above limit), the channel SHALL keep incrementing through 2^WIDTH-1, wrap to 0 without a tick, and then count normally.
REQ-026 A mode change SHALL take effect in the same cycle (last recomputed) and SHALL NOT by itself change count, done or tick.
REQ-027 Clearing mode bit0 while done is high SHALL NOT clear done; only set_valid or rst clears it.
REQ-028 Latency: count, done and tick SHALL reflect an input one cycle after it is sampled; last SHALL have zero latency relative to count, limit and mode.

Reset
REQ-029 With rst high at a clock edge, every channel SHALL reset count to 0, limit to 2^WIDTH-1, done to 0 and tick to 0, overriding set_valid, limit_valid and en.
REQ-030 rst asserted mid-count or mid-tick SHALL take effect at the next edge with no partial update; tick SHALL be low in the cycle after reset.
REQ-031 Immediately after reset, a channel in down mode SHALL show last high, because count is 0.

Verification
REQ-032 WIDTH=4, ch0 up/wrap, limit 5, en held 8 cycles from count 0 -> count 1,2,3,4,5,0,1,2; tick is high only in the cycle count first shows 0.
REQ-033 ch1 down/one-shot, set_value 3, en held -> count 2,1,0,0,...; done and a single tick rise in the cycle after en is sampled at 0; further en produces no tick.
REQ-034 ch2 at count 4, limit 4, up/wrap: set_valid (value 9) together with en -> count 9, no tick; then en continues 10..15,0 with no tick at the 15->0 wrap.
REQ-035 ch3 down/wrap at count 0, old limit 7: limit_valid (value 2) together with en -> count reloads to 7; later reloads use 2.
REQ-036 rst asserted while ch0 tick is high and ch1 done is high -> next cycle all counts 0, all limits 15, done 0, tick 0.
REQ-037 Independence: en on ch0 only for 3 cycles, with set_valid on ch1 (value 6) -> ch0 counts 1,2,3; ch1 loads 6 and then holds; ch2 and ch3 stay at 0.
